switch_pio_edge_irq: RTL and testbench

- Parametrised successor to the team's input-only switch PIO, as an Avalon-MM slave on the Nios system bus.
- Adds a 2-flop input synchroniser, per-bit edge capture with selectable edge type, and a per-bit interrupt mask driving a level IRQ to the Nios.
- Optional per-bit debounce filter for mechanical switches and push-buttons.
- Keeps 1-cycle registered read latency, so it drops into existing system integration unchanged.

---
 rtl/switch_pio_edge_irq.sv | 138 +++++++++++++
 tb/tb_switch_pio_edge_irq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/switch_pio_edge_irq.sv
// Avalon-MM switch PIO: 2-flop sync, edge capture, per-bit IRQ mask.
// Optional per-bit debounce filter under `SWITCH_PIO_DEBOUNCE_EN.
module switch_pio_edge_irq #(
    parameter int WIDTH           = 9,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] f;
    logic [WIDTH-1:0] rise, fall, e, clr;
    logic             wr_en;
    logic             unused_wdata;

    assign unused_wdata = &{1'b0, writedata};
    assign wr_en        = chipselect & ~write_n;

`ifdef SWITCH_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] f_q, f_d;

    // Any cycle where the synced input matches f restarts the count.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            f_d[i]   = f_q[i];
            if (s2_q[i] != f_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    f_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            f_q <= f_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign f = f_q;
`else
    assign f = s2_q;
`endif

    always_comb begin
        s1_d   = in_port;
        s2_d   = s1_q;
        prev_d = f;
        rise   = f & ~prev_q;
        fall   = ~f & prev_q;
        if (EDGE_TYPE == 0) begin
            e = rise;
        end else if (EDGE_TYPE == 1) begin
            e = fall;
        end else begin
            e = rise | fall;
        end
    end

    // A new edge in the same cycle as its W1C wins, so nothing is lost.
    always_comb begin
        clr    = '0;
        mask_d = mask_q;
        if (wr_en && address == 2'd3) begin
            clr = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd2) begin
            mask_d = writedata[WIDTH-1:0];
        end
        cap_d = (cap_q & ~clr) | e;
        irq_d = |(cap_q & mask_q);
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = f;
            2'd2:    readdata_d[WIDTH-1:0] = mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = cap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            prev_q     <= '0;
            cap_q      <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            prev_q     <= prev_d;
            cap_q      <= cap_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_switch_pio_edge_irq.sv
// Bench for switch_pio_edge_irq: three instances, one per EDGE_TYPE,
// sharing the bus; read results checked through a scoreboard queue.
module tb_switch_pio_edge_irq;

`ifdef SWITCH_PIO_DEBOUNCE_EN
    localparam int DB = 16;
`else
    localparam int DB = 0;
`endif
    localparam int LAT = 3 + DB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [8:0]  in_port = 9'd0;
    logic [31:0] rd0, rd1, rd2;
    logic [2:0]  irq_v;

    typedef struct {
        string       tag;
        int          dut;
        logic [31:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  n_chk = 0;
    int  n_fail = 0;

    always #5 clk = ~clk;

    switch_pio_edge_irq #(.WIDTH(9), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq_v[0])
    );
    switch_pio_edge_irq #(.WIDTH(9), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq_v[1])
    );
    switch_pio_edge_irq #(.WIDTH(9), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq_v[2])
    );

    function automatic logic [31:0] pick(int d);
        case (d)
            0:       return rd0;
            1:       return rd1;
            default: return rd2;
        endcase
    endfunction

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(logic [1:0] a, logic [31:0] e0, logic [31:0] e1,
                      logic [31:0] e2, string tag);
        sb_t s;
        sbq.push_back('{tag, 0, e0});
        sbq.push_back('{tag, 1, e1});
        sbq.push_back('{tag, 2, e2});
        address = a;
        step(1);
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            chk($sformatf("%s/dut%0d", s.tag, s.dut), pick(s.dut), s.exp);
        end
    endtask

    initial begin
        #(200000);
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_rd0", rd0, 32'h0);
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_rd2", rd2, 32'h0);
        chk("rst_irq", {29'd0, irq_v}, 32'h0);
        step(2);
        reset = 1'b0;

        in_port = 9'h1A5;
        step(LAT);
        rd(2'd0, 32'h1A5, 32'h1A5, 32'h1A5, "data");
        rd(2'd1, 32'h0, 32'h0, 32'h0, "reserved");
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, 32'h0, 32'h0, 32'h0, "reserved_wr");
        rd(2'd3, 32'h1A5, 32'h0, 32'h1A5, "cap_init");

        in_port = 9'h000;
        step(LAT + 1);
        wr(2'd3, 32'h1FF);
        rd(2'd3, 32'h0, 32'h0, 32'h0, "cap_clr_all");

        wr(2'd2, 32'h1);
        in_port[0] = 1'b1;
        step(LAT);
        chk("irq_pre", {29'd0, irq_v}, 32'h0);
        rd(2'd3, 32'h1, 32'h0, 32'h1, "cap_bit0");
        chk("irq_set", {29'd0, irq_v}, 32'h5);
        wr(2'd3, 32'h1);
        step(1);
        chk("irq_clr", {29'd0, irq_v}, 32'h0);
        rd(2'd3, 32'h0, 32'h0, 32'h0, "cap_w1c");

        in_port[3] = 1'b1;
        step(LAT);
        rd(2'd3, 32'h8, 32'h0, 32'h8, "rise3");
        in_port[3] = 1'b0;
        step(LAT);
        rd(2'd3, 32'h8, 32'h8, 32'h8, "fall3");
        chk("irq_masked_out", {29'd0, irq_v}, 32'h0);

        in_port[2] = 1'b1;
        step(LAT - 1);
        wr(2'd3, 32'h4);
        rd(2'd3, 32'hC, 32'h8, 32'hC, "collide");
        wr(2'd3, 32'h8);
        rd(2'd3, 32'h4, 32'h0, 32'h4, "clr3");

        in_port = 9'h000;
        step(LAT + 1);
        wr(2'd3, 32'h1FF);
        in_port = 9'h0FF;
        step(LAT);
        wr(2'd2, 32'hFF);
        step(1);
        chk("irq_pre_rst", {29'd0, irq_v}, 32'h5);
        rd(2'd3, 32'hFF, 32'h0, 32'hFF, "pre_rst_cap");
        rd(2'd2, 32'hFF, 32'hFF, 32'hFF, "pre_rst_mask");

        #2 reset = 1'b1;
        #1;
        chk("arst_rd0", rd0, 32'h0);
        chk("arst_rd1", rd1, 32'h0);
        chk("arst_rd2", rd2, 32'h0);
        chk("arst_irq", {29'd0, irq_v}, 32'h0);
        #1 reset = 1'b0;
        rd(2'd2, 32'h0, 32'h0, 32'h0, "post_rst_mask");
        rd(2'd3, 32'h0, 32'h0, 32'h0, "post_rst_cap");
        step(LAT);
        rd(2'd3, 32'hFF, 32'h0, 32'hFF, "post_rst_rise");

        wr(2'd2, 32'h1);
        step(1);
        chk("irq_mask_on", {29'd0, irq_v}, 32'h5);
        wr(2'd2, 32'h0);
        step(1);
        chk("irq_mask_off", {29'd0, irq_v}, 32'h0);

`ifdef SWITCH_PIO_DEBOUNCE_EN
        in_port = 9'h000;
        step(LAT + 2);
        wr(2'd3, 32'h1FF);
        for (int i = 0; i < 10; i++) begin
            in_port[1] = ~in_port[1];
            step(1);
        end
        in_port[1] = 1'b1;
        step(17);
        rd(2'd0, 32'h0, 32'h0, 32'h0, "db_before");
        rd(2'd0, 32'h2, 32'h2, 32'h2, "db_after");
        step(LAT);
        rd(2'd3, 32'h2, 32'h0, 32'h2, "db_once");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
